fir_mac_sequencer: RTL



---
 rtl/fir_pkg.sv | 18 +
 rtl/fir_mac_sequencer_if.sv | 30 +++
 rtl/sample_ring_ram.sv | 29 ++
 rtl/fir_mac_sequencer.sv | 117 +++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR MAC sequencer slice.
package fir_pkg;

    // Default tap-address MSB; the delay line holds 2^(ORDER_MSB+1) samples.
    localparam int DEFAULT_ORDER_MSB = 5;
    // Default MSB of the signed ADC sample word.
    localparam int DEFAULT_ADC_MSB   = 11;
    // Default tap count; also the address that parks the MAC.
    localparam int DEFAULT_TAPS      = 63;
    // Default delay-line depth.
    localparam int DEFAULT_DEPTH     = 2 ** (DEFAULT_ORDER_MSB + 1);

    typedef enum logic {
        IDLE,
        RUN
    } seq_state_t;

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample-in / MAC-out bundle of the FIR sequencer.
// The slave modport is the sequencer itself; the master modport is the
// surrounding logic that supplies samples and consumes the MAC stream.
interface fir_mac_sequencer_if
    import fir_pkg::*;
#(
    parameter int ORDER_MSB = DEFAULT_ORDER_MSB,
    parameter int ADC_MSB   = DEFAULT_ADC_MSB
);

    logic                      sample_valid;
    logic signed [ADC_MSB:0]   sample_in;
    logic                      busy;
    logic        [ORDER_MSB:0] coef_addr;
    logic        [ORDER_MSB:0] mac_address;
    logic signed [ADC_MSB:0]   mac_buffer_bits;
    logic                      result_valid;
    logic                      overrun;

    modport master (
        output sample_valid, sample_in,
        input  busy, coef_addr, mac_address, mac_buffer_bits, result_valid, overrun
    );

    modport slave (
        input  sample_valid, sample_in,
        output busy, coef_addr, mac_address, mac_buffer_bits, result_valid, overrun
    );

endinterface

// File: rtl/sample_ring_ram.sv
// Circular delay-line storage: one synchronous write port and one
// synchronous read port with a single cycle of read latency.
module sample_ring_ram #(
    parameter int ORDER_MSB = 5,
    parameter int ADC_MSB   = 11
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ORDER_MSB:0] waddr,
    input  logic [ADC_MSB:0]   wdata,
    input  logic [ORDER_MSB:0] raddr,
    output logic [ADC_MSB:0]   rdata
);

    localparam int DEPTH = 2 ** (ORDER_MSB + 1);

    logic [ADC_MSB:0] mem [DEPTH];

    // Write the new sample and register the addressed entry every cycle.
    // NOTE: no reset on the array or read register, so this maps onto block RAM;
    // stale contents are never consumed until the delay line has been refilled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Runs one pass of the FIR MAC per accepted sample: stores the sample in a
// circular delay line, walks the coefficient ROM and the delay line in step,
// and parks the MAC (zero product at a nonzero address) between frames.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int ORDER_MSB = DEFAULT_ORDER_MSB,
    parameter int ADC_MSB   = DEFAULT_ADC_MSB,
    parameter int TAPS      = DEFAULT_TAPS
) (
    input logic                clk,
    input logic                rst_n,
    fir_mac_sequencer_if.slave bus
);

    localparam int                 AW       = ORDER_MSB + 1;
    localparam logic [ORDER_MSB:0] TAP_IDLE = AW'(TAPS);
    localparam logic [ORDER_MSB:0] TAP_LAST = AW'(TAPS - 1);
    localparam logic [ORDER_MSB:0] TAP_ONE  = AW'(1);

    seq_state_t         state;
    logic [ORDER_MSB:0] k;             // tap being issued; doubles as coef_addr
    logic [ORDER_MSB:0] base;          // ring slot of the newest sample of this frame
    logic [ORDER_MSB:0] wr_ptr;
    logic [ORDER_MSB:0] fill;          // samples held, saturating at TAPS
    logic               prev_full;     // frame just finished had a full delay line
    logic               busy_q;
    logic [ORDER_MSB:0] mac_address_q;
    logic               tap_valid_q;   // ring read data belongs to an issued tap
    logic               result_valid_q;
    logic               overrun_q;

    logic               accept;
    logic [ORDER_MSB:0] rd_addr;
    logic [ADC_MSB:0]   ring_rdata;

    // A sample is only taken while idle; anything arriving in RUN is dropped.
    assign accept  = (state == IDLE) && bus.sample_valid;
    // Tap k reads the sample k slots older than the newest; wraps modulo DEPTH.
    assign rd_addr = base - k;

    sample_ring_ram #(
        .ORDER_MSB (ORDER_MSB),
        .ADC_MSB   (ADC_MSB)
    ) u_ring (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (bus.sample_in),
        .raddr (rd_addr),
        .rdata (ring_rdata)
    );

    // Frame sequencer plus the one-cycle-delayed MAC-side outputs.
    // NOTE: every register here is written with <= so all of them see the
    // pre-edge values of each other, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            k              <= '0;
            base           <= '0;
            wr_ptr         <= '0;
            fill           <= '0;
            prev_full      <= 1'b0;
            busy_q         <= 1'b0;
            mac_address_q  <= TAP_IDLE;
            tap_valid_q    <= 1'b0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            // Outputs trail the issued tap by one cycle to line up with the ROM.
            mac_address_q  <= (state == RUN) ? k : TAP_IDLE;
            tap_valid_q    <= (state == RUN);
            // The MAC commits when it sees address 0 (end of cycle 1), so the
            // previous frame's result is readable from cycle 2 onward.
            result_valid_q <= (state == RUN) && prev_full && (k == TAP_ONE);
            overrun_q      <= (state == RUN) && bus.sample_valid;

            case (state)
                IDLE: begin
                    if (bus.sample_valid) begin
                        base      <= wr_ptr;
                        wr_ptr    <= wr_ptr + 1'b1;
                        prev_full <= (fill == TAP_IDLE);
                        if (fill != TAP_IDLE) begin
                            fill <= fill + 1'b1;
                        end
                        k      <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (k == TAP_LAST) begin
                        k      <= '0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy            = busy_q;
    assign bus.coef_addr       = k;
    assign bus.mac_address     = mac_address_q;
    // Parked MAC needs a zero operand, so the raw RAM word is gated off when idle.
    assign bus.mac_buffer_bits = tap_valid_q ? $signed(ring_rdata) : '0;
    assign bus.result_valid    = result_valid_q;
    assign bus.overrun         = overrun_q;

endmodule
